// File: rtl/sramlike_bridge.sv
// Bridges a fixed-latency SRAM-style CPU port to a variable-latency req/addr_ok/data_ok bus.
// It holds off the core with cpu_stall and turns byte-write masks into size/address fields.
module sramlike_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [2:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                err_wen
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_wr_q, bus_wr_d;
  logic [2:0]          bus_size_q, bus_size_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                err_wen_q, err_wen_d;

  logic                mask_legal;
  logic [2:0]          mask_size;
  logic [OFF_W-1:0]    mask_off;
  logic                unused_addr_bits;

  // Request addresses are rebuilt from the upper bits, so the CPU's byte offset is never used.
  assign unused_addr_bits = ^cpu_addr[OFF_W-1:0];

  // A mask is legal when it is a naturally aligned run of 2^s ones.
  always_comb begin
    mask_legal = 1'b0;
    mask_size  = '0;
    mask_off   = '0;
    for (int s = 0; s <= int'(OFF_W); s++) begin
      for (int o = 0; o < int'(BYTES); o++) begin
        if (((o % (1 << s)) == 0) &&
            (cpu_wen == BYTES'(((1 << (1 << s)) - 1) << o))) begin
          mask_legal = 1'b1;
          mask_size  = 3'(s);
          mask_off   = OFF_W'(o);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cpu_rdata_q <= '0;
      err_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_wen_q   <= err_wen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    err_wen_d   = err_wen_q;
    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_wr_d    = |cpu_wen;
          bus_wdata_d = cpu_wdata;
          // Reads and illegal masks both become full-width, lane-0 transfers.
          if ((cpu_wen != '0) && mask_legal) begin
            bus_size_d = mask_size;
            bus_addr_d = {cpu_addr[ADDR_W-1:OFF_W], mask_off};
          end else begin
            bus_size_d = 3'(OFF_W);
            bus_addr_d = {cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            if (cpu_wen != '0) err_wen_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          if (bus_data_ok) begin
            state_d = DONE;
            if (!bus_wr_q) cpu_rdata_d = bus_rdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          state_d = DONE;
          if (!bus_wr_q) cpu_rdata_d = bus_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu_stall = cpu_en & (state_q != DONE);
  assign cpu_rdata = cpu_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign err_wen   = err_wen_q;

endmodule

// File: tb/tb_sramlike_bridge.sv
// Scoreboard bench for sramlike_bridge: stimulus queues expected bus requests and CPU results,
// monitors compare them when the DUT accepts a request or finishes an access.
module tb_sramlike_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  logic        clk, rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, bus_req, bus_wr;
  logic [2:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, slv_data_ok, stray_data_ok, err_wen;

  logic        c64_en;
  logic [7:0]  c64_wen;
  logic [31:0] c64_addr, b64_addr;
  logic [63:0] c64_wdata, c64_rdata, b64_wdata;
  logic        c64_stall, b64_req, b64_wr, err64;
  logic [2:0]  b64_size;

  int checks = 0;
  int errors = 0;

  req_t        exp_req_q[$];
  logic [31:0] exp_rsp_q[$];
  logic [31:0] model_rdata = 32'h0;

  int          cfg_okd = 0, cfg_dd = 0;
  logic [31:0] cfg_rdata = 32'h0;

  sramlike_bridge #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(slv_data_ok | stray_data_ok), .bus_rdata(bus_rdata), .err_wen(err_wen)
  );

  sramlike_bridge #(.ADDR_W(32), .DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .cpu_en(c64_en), .cpu_wen(c64_wen), .cpu_addr(c64_addr),
    .cpu_wdata(c64_wdata), .cpu_rdata(c64_rdata), .cpu_stall(c64_stall),
    .bus_req(b64_req), .bus_wr(b64_wr), .bus_size(b64_size), .bus_addr(b64_addr),
    .bus_wdata(b64_wdata), .bus_addr_ok(1'b1), .bus_data_ok(1'b1),
    .bus_rdata(64'h0123_4567_89AB_CDEF), .err_wen(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Slave: addr_ok cfg_okd cycles into REQ, data_ok cfg_dd cycles after addr_ok.
  initial begin
    int   acnt = 0, dcnt = 0;
    logic pend = 1'b0, prev_req = 1'b0;
    bus_addr_ok = 1'b0; slv_data_ok = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_addr_ok = 1'b0; slv_data_ok = 1'b0;
      if (rst) begin
        pend = 1'b0; prev_req = 1'b0;
      end else begin
        if (pend) begin
          if (dcnt == 0) begin slv_data_ok = 1'b1; bus_rdata = cfg_rdata; pend = 1'b0; end
          else dcnt--;
        end else if (bus_req) begin
          if (!prev_req) acnt = cfg_okd;
          if (acnt == 0) begin
            bus_addr_ok = 1'b1;
            if (cfg_dd == 0) begin slv_data_ok = 1'b1; bus_rdata = cfg_rdata; end
            else begin pend = 1'b1; dcnt = cfg_dd - 1; end
          end else acnt--;
        end
        prev_req = bus_req && !bus_addr_ok;
      end
    end
  end

  // Request monitor: fields stable while pending, compared against the queue on accept.
  initial begin
    logic        seen = 1'b0;
    logic [31:0] hold = '0;
    req_t        e;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (bus_req) begin
        if (!seen) begin seen = 1'b1; hold = bus_addr; end
        else chk("addr_hold", 64'(bus_addr), 64'(hold));
        if (cpu_en) chk("stall_in_req", 64'(cpu_stall), 64'd1);
        if (bus_addr_ok) begin
          seen = 1'b0;
          if (exp_req_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
          else begin
            e = exp_req_q.pop_front();
            chk("bus_addr", 64'(bus_addr), 64'(e.addr));
            chk("bus_size", 64'(bus_size), 64'(e.size));
            chk("bus_wr", 64'(bus_wr), 64'(e.wr));
            chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
          end
        end
      end
    end
  end

  // Completion monitor: DONE cycle is cpu_en with stall low.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && cpu_en && !cpu_stall) begin
        chk("req_low_in_done", 64'(bus_req), 64'd0);
        if (exp_rsp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = exp_rsp_q.pop_front();
          chk("cpu_rdata", 64'(cpu_rdata), 64'(e));
        end
      end
    end
  end

  task automatic xfer(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input int okd, input int dd, input logic [31:0] rdata,
                      input logic [31:0] exp_addr, input logic [2:0] exp_size, input int exp_cyc);
    req_t r;
    int   n = 0;
    r.addr = exp_addr; r.size = exp_size; r.wr = (wen != 4'h0); r.wdata = wdata;
    exp_req_q.push_back(r);
    if (wen == 4'h0) model_rdata = rdata;
    exp_rsp_q.push_back(model_rdata);
    @(posedge clk); #1;
    cfg_okd = okd; cfg_dd = dd; cfg_rdata = rdata;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    do begin @(negedge clk); n++; end while (cpu_stall && n < 60);
    chk("done_reached", 64'(cpu_stall), 64'd0);
    chk("access_cycles", 64'(n), 64'(exp_cyc));
  endtask

  task automatic idle_cpu();
    @(posedge clk); #1;
    cpu_en = 1'b0;
  endtask

  task automatic x64(input logic [7:0] wen, input logic [31:0] addr, input logic [31:0] exp_addr,
                     input logic [2:0] exp_size, input logic exp_err);
    @(posedge clk); #1;
    c64_en = 1'b1; c64_wen = wen; c64_addr = addr; c64_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    @(negedge clk);
    @(negedge clk);
    chk("b64_req", 64'(b64_req), 64'd1);
    chk("b64_addr", 64'(b64_addr), 64'(exp_addr));
    chk("b64_size", 64'(b64_size), 64'(exp_size));
    chk("b64_wr", 64'(b64_wr), 64'd1);
    chk("err64", 64'(err64), 64'(exp_err));
    @(negedge clk);
    chk("c64_done", 64'(c64_stall), 64'd0);
    @(posedge clk); #1;
    c64_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stray_data_ok = 1'b0;
    cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    c64_en = 1'b0; c64_wen = '0; c64_addr = '0; c64_wdata = '0;
    #1;
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_size", 64'(bus_size), 64'd0);
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_err_wen", 64'(err_wen), 64'd0);
    chk("rst_stall_idle", 64'(cpu_stall), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic read: IDLE, REQ, WAIT, WAIT, DONE.
    xfer(4'h0, 32'h1000_0006, 32'h0, 0, 2, 32'hDEAD_BEEF, 32'h1000_0004, 3'd2, 5);
    idle_cpu();
    // Writes: 3-cycle accesses, rdata must stay at DEADBEEF.
    xfer(4'b0100, 32'h2000_0000, 32'h00AB_0000, 0, 0, 32'h1111_1111, 32'h2000_0002, 3'd0, 3);
    xfer(4'b1100, 32'h2000_0000, 32'hCDEF_0000, 0, 0, 32'h2222_2222, 32'h2000_0002, 3'd1, 3);
    xfer(4'b1111, 32'h2000_0000, 32'h1234_5678, 0, 0, 32'h3333_3333, 32'h2000_0000, 3'd2, 3);
    idle_cpu();
    chk("err_after_legal", 64'(err_wen), 64'd0);
    // Same-cycle accept on a read.
    xfer(4'h0, 32'h3000_000B, 32'h0, 0, 0, 32'hCAFE_F00D, 32'h3000_0008, 3'd2, 3);
    // Back-to-back reads with addr_ok delayed 4 cycles; cpu_en never drops in between.
    xfer(4'h0, 32'h4000_0010, 32'h0, 4, 0, 32'h0BAD_F00D, 32'h4000_0010, 3'd2, 7);
    xfer(4'h0, 32'h4000_0021, 32'h0, 4, 1, 32'h7654_3210, 32'h4000_0020, 3'd2, 8);
    idle_cpu();
    // Illegal mask: full-width write and sticky error.
    xfer(4'b0110, 32'h5000_0003, 32'h0055_6600, 0, 0, 32'h0, 32'h5000_0000, 3'd2, 3);
    idle_cpu();
    chk("err_set", 64'(err_wen), 64'd1);
    xfer(4'b0011, 32'h5000_0000, 32'h0000_7788, 1, 0, 32'h0, 32'h5000_0000, 3'd1, 4);
    idle_cpu();
    chk("err_sticky", 64'(err_wen), 64'd1);
    chk("rdata_kept", 64'(cpu_rdata), 64'h7654_3210);

    // 64-bit instance mask mapping.
    x64(8'hF0, 32'h6000_0000, 32'h6000_0004, 3'd2, 1'b0);
    x64(8'h0C, 32'h6000_0010, 32'h6000_0012, 3'd1, 1'b0);
    x64(8'hFF, 32'h6000_0025, 32'h6000_0020, 3'd3, 1'b0);
    x64(8'h3C, 32'h6000_0030, 32'h6000_0030, 3'd3, 1'b1);

    // Async reset in the middle of WAIT.
    begin
      req_t r;
      r.addr = 32'h7000_0000; r.size = 3'd2; r.wr = 1'b0; r.wdata = 32'h0;
      exp_req_q.push_back(r);
      @(posedge clk); #1;
      cfg_okd = 0; cfg_dd = 20; cfg_rdata = 32'hFFFF_FFFF;
      cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h7000_0000; cpu_wdata = '0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("wait_stall", 64'(cpu_stall), 64'd1);
      chk("wait_req_low", 64'(bus_req), 64'd0);
      #2 rst = 1'b1; cpu_en = 1'b0;
      #1;
      chk("arst_bus_req", 64'(bus_req), 64'd0);
      chk("arst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      chk("arst_err_wen", 64'(err_wen), 64'd0);
      chk("arst_bus_addr", 64'(bus_addr), 64'd0);
      chk("arst_err64", 64'(err64), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      model_rdata = 32'h0;
      cfg_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1 stray_data_ok = 1'b1;
        @(negedge clk);
        chk("stray_rdata", 64'(cpu_rdata), 64'd0);
        chk("stray_req", 64'(bus_req), 64'd0);
      end
      @(posedge clk); #1 stray_data_ok = 1'b0;
    end
    // After reset the bridge must still work normally.
    xfer(4'h0, 32'h8000_0004, 32'h0, 0, 0, 32'h5A5A_A5A5, 32'h8000_0004, 3'd2, 3);
    idle_cpu();
    repeat (2) @(negedge clk);
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sramlike_bridge.md
Name: sramlike_bridge

Overview:
- Bridges the CPU core's fixed-latency SRAM-style memory port (en/wen/addr/wdata/rdata) to a variable-latency SRAM-like handshake bus (req/addr_ok/data_ok).
- Generates a stall back to the core while a transfer is in flight.
- Converts byte-write masks into size and address fields.
- One instance sits on the instruction path and one on the data path, between the core and the bus/cache.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; legal values 32 or 64. Byte-mask width is DATA_W/8.
- OFF_W, log2(DATA_W/8), derived (localparam). Number of byte-offset address bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_en  in  1  CPU access request; held stable with the other cpu_* inputs while cpu_stall=1
- cpu_wen  in  DATA_W/8  byte write mask; 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data, lane-aligned
- cpu_rdata  out  DATA_W  read data, valid in the DONE cycle
- cpu_stall  out  1  CPU must hold its request
- bus_req  out  1  request valid
- bus_wr  out  1  1 = write
- bus_size  out  3  log2 of transfer bytes
- bus_addr  out  ADDR_W  request address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  request accepted this cycle (when bus_req=1)
- bus_data_ok  in  1  transfer complete; bus_rdata valid
- bus_rdata  in  DATA_W  read data
- err_wen  out  1  sticky: illegal byte mask seen

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - bus_req, bus_wr, bus_size, bus_addr, bus_wdata, cpu_rdata, err_wen all 0.
- cpu_stall is combinational: cpu_en & (state != DONE). With cpu_en=0 it is 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, cpu_en=1 -> REQ. On this edge, register:
  - bus_wr = |cpu_wen
  - bus_size, bus_addr from the mask (rules below)
  - bus_wdata = cpu_wdata
- IDLE, cpu_en=0 -> stay in IDLE.
- REQ:
  - bus_req=1; all bus_* fields held constant until addr_ok.
  - addr_ok=1 & data_ok=0 -> WAIT.
  - addr_ok=1 & data_ok=1 (same cycle) -> DONE.
  - Deassert bus_req on leaving REQ.
- WAIT: bus_req=0; on data_ok -> DONE.
- cpu_rdata capture:
  - On the data_ok edge, cpu_rdata <= bus_rdata for reads; writes leave cpu_rdata unchanged.
  - cpu_rdata holds its value until the next read completes.
- DONE:
  - Lasts exactly one cycle; cpu_stall=0 so the CPU consumes the result. Unconditional -> IDLE.
  - A new request is first seen in IDLE.
  - Minimum access time: 3 cycles (IDLE, REQ with addr_ok and data_ok together, DONE).
- data_ok seen in IDLE or REQ-without-addr_ok is ignored. Only one transfer is outstanding at a time.
- Mask mapping, for a non-zero mask with n set bits:
  - Legal when n is a power of two (1, 2, 4 or 8 up to DATA_W/8), the set bits are contiguous, and the lowest set index i is a multiple of n.
  - Legal mask: bus_size = log2(n); bus_addr = {cpu_addr[ADDR_W-1:OFF_W], i}.
  - Illegal mask: issue a full-width write (size = OFF_W, offset 0, wdata as given) and set err_wen. err_wen clears only on rst.
- Reads (mask 0): bus_size = OFF_W; bus_addr = cpu_addr with the low OFF_W bits forced to 0. The CPU performs lane extraction.
- cpu_en dropped mid-transfer violates the protocol. The transfer still completes through DONE.

Test Plan:
- Basic read, DATA_W=32: cpu_en=1, wen=0, addr=0x1000_0006; slave gives addr_ok in REQ and data_ok 2 cycles later with rdata=0xDEADBEEF.
  - Expect bus_addr=0x1000_0004, size=2, wr=0.
  - Expect stall high until the DONE cycle, then cpu_rdata=0xDEADBEEF.
- Write masks, DATA_W=32, addr=0x2000_0000:
  - wen=0100 -> size=0, addr=0x2000_0002
  - wen=1100 -> size=1, addr=0x2000_0002
  - wen=1111 -> size=2, addr=0x2000_0000
  - bus_wr=1 in all cases; cpu_rdata unchanged.
- Same-cycle accept: addr_ok and data_ok both high in the first REQ cycle.
  - Expect DONE next cycle (3-cycle total) and bus_req low in DONE.
- Back-to-back and stall hold:
  - Two reads with addr_ok delayed 4 cycles: bus_req stays high with stable addr; stall stays high for the whole wait.
  - Second request issued after DONE; its req appears 1 cycle after IDLE.
- Illegal mask and 64-bit: wen=0110 at DATA_W=32 -> size=2, offset 0, err_wen=1 and sticky. At DATA_W=64, wen=0xF0 -> size=2, addr offset 4.
- Async reset mid-WAIT: assert rst between clock edges.
  - Expect bus_req=0, cpu_rdata=0, err_wen=0 immediately and state=IDLE.
  - A stray data_ok after reset release is ignored.
